qfas_bist: RTL and testbench

- Built-in self-test controller for the 4-bit adder/subtractor (qfas) interface.
- Sits at the opposite end of that interface from the datapath: drives A/B/SEL/CI into a qfas instance and consumes Y/CO.
- Sweeps every input combination, compares each result against an internal golden model, and reports pass/fail plus an error count.
- Replaces hand-written vector lists with an exhaustive, synthesizable checker.

---
 rtl/qfas_pkg.sv | 17 +
 rtl/qfas_ref.sv | 23 ++
 rtl/qfas_bist.sv | 160 ++++++++++++++++
 tb/tb_qfas_bist.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/qfas_pkg.sv
// Shared types and golden arithmetic for the qfas 4-bit adder/subtractor interface.
// Purely declarative: no latency, no flow control.
package qfas_pkg;

  localparam int QFAS_W = 4;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} bist_state_t;

  // Subtract is A + ~B + ~CI, so CO=1 means "no borrow".
  function automatic logic [QFAS_W:0] qfas_golden(input logic [QFAS_W-1:0] a,
                                                  input logic [QFAS_W-1:0] b,
                                                  input logic              sel,
                                                  input logic              ci);
    return {1'b0, a} + {1'b0, b ^ {QFAS_W{sel}}} + {{QFAS_W{1'b0}}, ci ^ sel};
  endfunction

endpackage

// File: rtl/qfas_ref.sv
// Combinational golden model of the qfas adder/subtractor; zero latency, no backpressure.
module qfas_ref
  import qfas_pkg::*;
#(
  parameter int WIDTH = QFAS_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             ci,
  output logic [WIDTH:0]   gold
);

  // Non-default widths fall back to the same equation written generically.
  generate
    if (WIDTH == QFAS_W) begin : g_pkg
      assign gold = qfas_golden(a, b, sel, ci);
    end else begin : g_gen
      assign gold = {1'b0, a} + {1'b0, b ^ {WIDTH{sel}}} + {{WIDTH{1'b0}}, ci ^ sel};
    end
  endgenerate

endmodule

// File: rtl/qfas_bist.sv
// Exhaustive BIST for a qfas instance: SETTLE+1 cycles per vector, start ignored while busy.
// Optional first-failure capture port under QFAS_BIST_CAPTURE_EN.
module qfas_bist
  import qfas_pkg::*;
#(
  parameter int WIDTH  = QFAS_W,
  parameter int SETTLE = 1,
  parameter int ERRW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERRW-1:0]      err_cnt,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_sel,
  output logic                 dut_ci,
  input  logic [WIDTH-1:0]     dut_y,
  input  logic                 dut_co
`ifdef QFAS_BIST_CAPTURE_EN
  ,
  output logic                 fail_valid,
  output logic [2*WIDTH+1:0]   fail_vec
`endif
);

  localparam int IW = 2 * WIDTH + 2;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  bist_state_t       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [WIDTH:0]    gold;
  logic              mismatch;
`ifdef QFAS_BIST_CAPTURE_EN
  logic              fail_valid_q, fail_valid_d;
  logic [IW-1:0]     fail_vec_q, fail_vec_d;
`endif

  qfas_ref #(.WIDTH(WIDTH)) u_ref (
    .a    (idx_q[WIDTH-1:0]),
    .b    (idx_q[2*WIDTH-1:WIDTH]),
    .sel  (idx_q[IW-1]),
    .ci   (idx_q[2*WIDTH]),
    .gold (gold)
  );

  assign mismatch = ({dut_co, dut_y} != gold);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    err_cnt_d = err_cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
`ifdef QFAS_BIST_CAPTURE_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = APPLY;
          idx_d     = '0;
          settle_d  = '0;
          err_cnt_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
`ifdef QFAS_BIST_CAPTURE_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
`endif
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
`ifdef QFAS_BIST_CAPTURE_EN
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = idx_q;
          end
`endif
        end
        // idx parks at all-ones once the sweep ends.
        if (idx_q == '1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      settle_q  <= '0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef QFAS_BIST_CAPTURE_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef QFAS_BIST_CAPTURE_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign dut_a   = idx_q[WIDTH-1:0];
  assign dut_b   = idx_q[2*WIDTH-1:WIDTH];
  assign dut_ci  = idx_q[2*WIDTH];
  assign dut_sel = idx_q[IW-1];
`ifdef QFAS_BIST_CAPTURE_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_qfas_bist.sv
// Bench for qfas_bist: attaches a behavioural adder/subtractor with selectable faults.
module tb_qfas_bist;

  localparam int SETTLE = 1;
  localparam int SWEEP  = 1024 * (SETTLE + 1);

  logic        clk = 1'b0;
  logic        rst_n, start, start4;
  int          fault_mode;

  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [3:0]  dut_a, dut_b, dut_y;
  logic        dut_sel, dut_ci, dut_co;

  logic        busy4, done4, pass4;
  logic [3:0]  err_cnt4;
  logic [3:0]  dut_a4, dut_b4, dut_y4;
  logic        dut_sel4, dut_ci4, dut_co4;
`ifdef QFAS_BIST_CAPTURE_EN
  logic        fail_valid, fail_valid4;
  logic [9:0]  fail_vec, fail_vec4;
`endif

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic        fvalid;
    logic [9:0]  fvec;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Independent reference: plain integer add/subtract, with the three
  // hand-worked vectors hardwired so the DUT golden model is checked against them.
  function automatic logic [4:0] tb_adder(input logic [3:0] a, input logic [3:0] b,
                                          input logic sel, input logic ci, input int mode);
    int r;
    logic [4:0] o;
    if (!sel) begin
      r = int'(a) + int'(b) + int'(ci);
      o = r[4:0];
    end else begin
      r = int'(a) - int'(b) - int'(ci);
      o = {r >= 0, r[3:0]};
    end
    if ({sel, ci, a, b} == {2'b00, 4'b0101, 4'b1010}) o = 5'b01111;
    if ({sel, ci, a, b} == {2'b10, 4'b0100, 4'b0011}) o = 5'b10001;
    if ({sel, ci, a, b} == {2'b10, 4'b1010, 4'b1011}) o = 5'b01111;
    if (mode == 1) o[0] = 1'b0;
    if (mode == 2) o[4] = ~o[4];
    return o;
  endfunction

  always_comb {dut_co, dut_y}   = tb_adder(dut_a, dut_b, dut_sel, dut_ci, fault_mode);
  always_comb {dut_co4, dut_y4} = tb_adder(dut_a4, dut_b4, dut_sel4, dut_ci4, 2);

  qfas_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .dut_a(dut_a), .dut_b(dut_b), .dut_sel(dut_sel), .dut_ci(dut_ci),
    .dut_y(dut_y), .dut_co(dut_co)
`ifdef QFAS_BIST_CAPTURE_EN
    , .fail_valid(fail_valid), .fail_vec(fail_vec)
`endif
  );

  qfas_bist #(.ERRW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err_cnt4), .dut_a(dut_a4), .dut_b(dut_b4), .dut_sel(dut_sel4), .dut_ci(dut_ci4),
    .dut_y(dut_y4), .dut_co(dut_co4)
`ifdef QFAS_BIST_CAPTURE_EN
    , .fail_valid(fail_valid4), .fail_vec(fail_vec4)
`endif
  );

  task automatic run_sweep(input int mode, input bit poke, input logic exp_pass,
                           input logic [15:0] exp_err, input logic exp_fvalid,
                           input logic [9:0] exp_fvec);
    exp_t e;
    int cyc, overlap, maperr;
    int exp_idx;
    fault_mode = mode;
    sb_q.push_back('{exp_pass, exp_err, exp_fvalid, exp_fvec});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if ({busy, done, pass} !== 3'b100) $display("FAIL accept_flags got busy/done/pass=%b want 100", {busy, done, pass}); else n_pass++;
    n_checks++; if (err_cnt !== 16'd0) $display("FAIL accept_err_clear got %0d want 0", err_cnt); else n_pass++;
`ifdef QFAS_BIST_CAPTURE_EN
    n_checks++; if (fail_valid !== 1'b0) $display("FAIL accept_fvalid_clear got %b want 0", fail_valid); else n_pass++;
`endif
    cyc = 0; overlap = 0; maperr = 0;
    for (int t = 0; t < 5000; t++) begin
      if (busy && done) overlap++;
      if (busy) begin
        exp_idx = cyc / (SETTLE + 1);
        if ({dut_sel, dut_ci, dut_b, dut_a} !== exp_idx[9:0]) maperr++;
        cyc++;
      end
      if (done) break;
      start = (poke && t == 100);
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (done !== 1'b1) $display("FAIL sweep_done got %b want 1 (busy cycles %0d)", done, cyc); else n_pass++;
    n_checks++; if (cyc !== SWEEP) $display("FAIL sweep_len got %0d want %0d", cyc, SWEEP); else n_pass++;
    n_checks++; if (overlap !== 0) $display("FAIL busy_done_overlap got %0d want 0", overlap); else n_pass++;
    n_checks++; if (maperr !== 0) $display("FAIL vector_mapping got %0d bad cycles want 0", maperr); else n_pass++;
    n_checks++; if (pass !== e.pass) $display("FAIL sweep_pass got %b want %b", pass, e.pass); else n_pass++;
    n_checks++; if (err_cnt !== e.err) $display("FAIL sweep_err_cnt got %0d want %0d", err_cnt, e.err); else n_pass++;
    n_checks++; if ({dut_sel, dut_ci, dut_b, dut_a} !== 10'h3FF) $display("FAIL done_idx got %h want 3ff", {dut_sel, dut_ci, dut_b, dut_a}); else n_pass++;
`ifdef QFAS_BIST_CAPTURE_EN
    n_checks++; if (fail_valid !== e.fvalid) $display("FAIL fail_valid got %b want %b", fail_valid, e.fvalid); else n_pass++;
    n_checks++; if (fail_vec !== e.fvec) $display("FAIL fail_vec got %h want %h", fail_vec, e.fvec); else n_pass++;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; fault_mode = 0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, pass}); else n_pass++;
    n_checks++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
    n_checks++; if ({dut_sel, dut_ci, dut_b, dut_a} !== 10'd0) $display("FAIL reset_drive got %h want 000", {dut_sel, dut_ci, dut_b, dut_a}); else n_pass++;
    n_checks++; if ({busy4, done4, pass4, err_cnt4} !== 7'd0) $display("FAIL reset_sat_inst got %b want 0", {busy4, done4, pass4, err_cnt4}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_start got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_clean_sweep;
    run_sweep(0, 1'b0, 1'b1, 16'd0, 1'b0, 10'h000);
  endtask

  task automatic test_start_while_busy;
    run_sweep(0, 1'b1, 1'b1, 16'd0, 1'b0, 10'h000);
  endtask

  task automatic test_fault_stuck;
    run_sweep(1, 1'b0, 1'b0, 16'd512, 1'b1, 10'h001);
  endtask

  task automatic test_start_in_done;
    n_checks++; if ({done, err_cnt} !== {1'b1, 16'd512}) $display("FAIL pre_restart got done=%b err=%0d want 1/512", done, err_cnt); else n_pass++;
    run_sweep(0, 1'b0, 1'b1, 16'd0, 1'b0, 10'h000);
  endtask

  task automatic test_mid_reset;
    fault_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if ({dut_sel, dut_ci, dut_b, dut_a} == 10'd300) break;
      @(negedge clk);
    end
    n_checks++; if ({dut_sel, dut_ci, dut_b, dut_a} !== 10'd300) $display("FAIL reach_idx300 got %0d want 300", {dut_sel, dut_ci, dut_b, dut_a}); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if ({busy, done, pass, err_cnt} !== 19'd0) $display("FAIL midreset_flags got %h want 0", {busy, done, pass, err_cnt}); else n_pass++;
    n_checks++; if ({dut_sel, dut_ci, dut_b, dut_a} !== 10'd0) $display("FAIL midreset_drive got %h want 000", {dut_sel, dut_ci, dut_b, dut_a}); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_idle got busy=%b want 0", busy); else n_pass++;
    run_sweep(0, 1'b0, 1'b1, 16'd0, 1'b0, 10'h000);
  endtask

  task automatic test_saturate;
    exp_t e;
    sb_q.push_back('{1'b0, 16'd15, 1'b1, 10'h000});
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      if (done4) break;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    n_checks++; if (done4 !== 1'b1) $display("FAIL sat_done got %b want 1", done4); else n_pass++;
    n_checks++; if ({12'd0, err_cnt4} !== e.err) $display("FAIL sat_err_cnt got %0d want %0d", err_cnt4, e.err); else n_pass++;
    n_checks++; if (pass4 !== e.pass) $display("FAIL sat_pass got %b want %b", pass4, e.pass); else n_pass++;
`ifdef QFAS_BIST_CAPTURE_EN
    n_checks++; if ({fail_valid4, fail_vec4} !== {e.fvalid, e.fvec}) $display("FAIL sat_capture got %b/%h want %b/%h", fail_valid4, fail_vec4, e.fvalid, e.fvec); else n_pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_clean_sweep;
    test_start_while_busy;
    test_fault_stuck;
    test_start_in_done;
    test_mid_reset;
    test_saturate;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
